// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache request port among 2**SEL_BITS requesters.
// The winner's payload is registered and offered downstream with valid/ready.
// When the payload is accepted, the winner gets a one-cycle ack.
// Optional macro CACHE_ARB_LOCK_EN adds a per-requester lock input. It keeps a
// multi-beat burst on the same requester across consecutive grants.
module cache_req_arbiter #(
  parameter int WIDTH    = 32,
  parameter int SEL_BITS = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [(2**SEL_BITS)-1:0]        req,
  input  logic [WIDTH*(2**SEL_BITS)-1:0]  in_bus,
  output logic [(2**SEL_BITS)-1:0]        ack,
  output logic [SEL_BITS-1:0]             sel,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  input  logic                            out_ready,
`ifdef CACHE_ARB_LOCK_EN
  input  logic [(2**SEL_BITS)-1:0]        lock,
`endif
  output logic                            busy
);

  localparam int N = 2**SEL_BITS;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, next_state;
  logic [SEL_BITS-1:0] rr_ptr;
  logic                lock_hold;
  logic                lock_acc;
  logic [SEL_BITS-1:0] start, idx, scan_win, win;
  logic [N-1:0]        cand;
  logic                found, grant;
  logic [WIDTH-1:0]    slice [N];

`ifdef CACHE_ARB_LOCK_EN
  assign lock_acc = lock[sel];
`else
  assign lock_acc = 1'b0;
`endif

  assign busy      = (state == GRANT);
  assign out_valid = (state == GRANT);

  // Split the packed payload bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slice[i] = in_bus[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin scan. The requester acked this cycle is masked out, so it
  // cannot win twice in a row. After a locked accept the scan starts past sel.
  always_comb begin
    start    = lock_hold ? sel + SEL_BITS'(1) : rr_ptr;
    cand     = req & ~ack;
    found    = 1'b0;
    scan_win = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = start + SEL_BITS'(i);
      if (!found && cand[idx]) begin
        found    = 1'b1;
        scan_win = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and winner choice. A locked requester that still requests wins first.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    win        = scan_win;
    case (state)
      IDLE: begin
        if (lock_hold && req[sel]) begin
          grant = 1'b1;
          win   = sel;
        end else if (found) begin
          grant = 1'b1;
        end
        if (grant) next_state = GRANT;
      end
      GRANT: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch the winner on grant edges; pulse ack and move the pointer on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack       <= '0;
      sel       <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      lock_hold <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          lock_hold <= 1'b0;
          if (grant) begin
            sel      <= win;
            out_data <= slice[win];
          end else if (lock_hold) begin
            rr_ptr <= sel + SEL_BITS'(1);
          end
        end
        GRANT: begin
          if (out_ready) begin
            ack       <= N'(1) << sel;
            lock_hold <= lock_acc;
            if (!lock_acc) rr_ptr <= sel + SEL_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed-vector bench for cache_req_arbiter (default parameters, N = 8).
// Define CACHE_ARB_LOCK_EN to also exercise the burst-lock path.
module tb_cache_req_arbiter;

  localparam int WIDTH = 32;
  localparam int SEL_BITS = 3;
  localparam int N = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [WIDTH*N-1:0] in_bus;
  logic [N-1:0]     ack;
  logic [SEL_BITS-1:0] sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
`ifdef CACHE_ARB_LOCK_EN
  logic [N-1:0]     lock;
`endif

  int n_vec = 0;
  int n_err = 0;

  cache_req_arbiter #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
    .clk(clk), .reset(reset), .req(req), .in_bus(in_bus), .ack(ack), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef CACHE_ARB_LOCK_EN
    .lock(lock),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pay(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic load_payloads();
    for (int i = 0; i < N; i++) in_bus[i*WIDTH +: WIDTH] = pay(i);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Bounded wait for out_valid, then check winner, payload and the following ack.
  task automatic grant_accept(input string tag, input int exp_sel, input logic [WIDTH-1:0] exp_data);
    int cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sel"}, 64'(sel), 64'(exp_sel));
    chk({tag, "_data"}, 64'(out_data), 64'(exp_data));
    @(negedge clk);
    chk({tag, "_ack"}, 64'(ack), 64'(N'(1) << exp_sel));
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0; in_bus = '0;
`ifdef CACHE_ARB_LOCK_EN
    lock = '0;
`endif
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    do_reset();

    // Single request: latency of one edge and exact ack timing.
    in_bus[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    req = 8'b0000_0100;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_sel", 64'(sel), 64'd2);
    chk("t1_data", 64'(out_data), 64'hDEADBEEF);
    chk("t1_ack_early", 64'(ack), 64'd0);
    @(negedge clk);
    chk("t1_ack", 64'(ack), 64'h04);
    chk("t1_valid_off", 64'(out_valid), 64'd0);
    chk("t1_rr_ptr", 64'(dut.rr_ptr), 64'd3);
    req = '0;
    @(negedge clk);
    chk("t1_ack_once", 64'(ack), 64'd0);

    // All requesting: strict 0..7,0 order at one grant per two cycles.
    do_reset();
    load_payloads();
    req = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_sel", 64'(sel), 64'(k % N));
      chk("rr_data", 64'(out_data), 64'(pay(k % N)));
      @(negedge clk);
      chk("rr_ack", 64'(ack), 64'(N'(1) << (k % N)));
      chk("rr_idle", 64'(out_valid), 64'd0);
    end
    req = '0;

    // Backpressure: winner and payload held while inputs churn.
    do_reset();
    load_payloads();
    out_ready = 1'b0;
    req = 8'h20;
    @(negedge clk);
    chk("bp_sel0", 64'(sel), 64'd5);
    for (int c = 0; c < 10; c++) begin
      in_bus = {8{$urandom()}};
      req = 8'($urandom());
      @(negedge clk);
      chk("bp_sel", 64'(sel), 64'd5);
      chk("bp_data", 64'(out_data), 64'(pay(5)));
      chk("bp_ack", 64'(ack), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    req = '0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack_rel", 64'(ack), 64'h20);
    @(negedge clk);
    chk("bp_ack_single", 64'(ack), 64'd0);
    chk("bp_idle", 64'(out_valid), 64'd0);

    // Reset in the middle of a grant clears outputs without waiting for a clock.
    do_reset();
    load_payloads();
    out_ready = 1'b0;
    req = 8'h10;
    @(negedge clk);
    chk("mr_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ack", 64'(ack), 64'd0);
    chk("mr_sel", 64'(sel), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    req = 8'h01;
    out_ready = 1'b1;
    grant_accept("mr_post", 0, pay(0));
    req = '0;

    // Wrap-around: pointer at 7, requesters 7 and 0 pending.
    do_reset();
    load_payloads();
    out_ready = 1'b1;
    req = 8'h40;
    grant_accept("wr_pre", 6, pay(6));
    chk("wr_ptr", 64'(dut.rr_ptr), 64'd7);
    req = 8'h81;
    grant_accept("wr_first", 7, pay(7));
    grant_accept("wr_second", 0, pay(0));
    req = '0;

`ifdef CACHE_ARB_LOCK_EN
    // Locked burst: requester 0 keeps the port for three beats, then 3 wins.
    do_reset();
    load_payloads();
    out_ready = 1'b1;
    lock = 8'h01;
    req = 8'h09;
    grant_accept("lk_b1", 0, pay(0));
    grant_accept("lk_b2", 0, pay(0));
    grant_accept("lk_b3", 0, pay(0));
    req = 8'h08;
    lock = '0;
    grant_accept("lk_after", 3, pay(3));
    req = '0;
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
Round-robin arbiter that shares one cache request port among 2**SEL_BITS requesters.
- Each requester presents a request bit and a WIDTH-bit payload. Payloads are packed into one bus; requester i occupies bits [WIDTH*(i+1)-1 : WIDTH*i].
- The arbiter picks a winner, drives the select index for the cache's payload mux, registers the selected payload and presents it downstream with a valid/ready handshake.
- It returns a one-cycle ack to the winner when the payload is accepted.

Parameters:
- WIDTH, 32, payload width per requester.
- SEL_BITS, 3, select width; N = 2**SEL_BITS requesters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request bit per requester; level-held until that requester's ack.
- in_bus  input  WIDTH*N  packed payloads; requester i at [WIDTH*(i+1)-1 : WIDTH*i].
- ack  output  N  one-hot, one-cycle pulse to the requester whose payload was accepted.
- sel  output  SEL_BITS  index of the current or last winner.
- out_valid  output  1  downstream payload valid.
- out_data  output  WIDTH  registered payload of the winner.
- out_ready  input  1  downstream accept.
- busy  output  1  high whenever in the GRANT state.

Behaviour:
- Reset values: ack=0, sel=0, out_valid=0, out_data=0, busy=0, rr_ptr=0, state=IDLE.
- States: IDLE and GRANT.
- IDLE:
  - If req is nonzero, choose winner w = first set bit of req scanning from rr_ptr upward, wrapping from N-1 to 0.
  - On the same clock edge: sel<=w, out_data<=in_bus slice w, out_valid<=1, state<=GRANT.
  - If req is zero, stay in IDLE; all outputs hold, out_valid stays 0.
- GRANT:
  - out_valid=1. sel and out_data are held stable regardless of req or in_bus changes.
  - On out_valid&&out_ready: ack[sel]<=1 for exactly one cycle, out_valid<=0, rr_ptr<=(sel+1) mod N (wraps), state<=IDLE.
  - Without out_ready, stay in GRANT indefinitely.
- Latency and throughput:
  - req rises at edge t → out_valid high after edge t+1.
  - Minimum spacing between grants is 2 cycles: one IDLE cycle after each accept.
- A requester must hold req and its payload until it sees ack.
  - If req drops while that requester is granted, the transaction still completes with the latched payload and ack still pulses.
  - The ack cycle coincides with the IDLE cycle. The acked requester's req is still high in that cycle but is excluded from that cycle's arbitration; any other pending requester may win.
- Fairness: with all N requesters continuously requesting, grants occur in order rr_ptr, rr_ptr+1, … with no requester starved for more than N grants.
- Simultaneous events: a new req arriving while in GRANT only affects the next arbitration.
- Reset asserted mid-GRANT: out_valid and ack clear immediately (asynchronously); the transaction is dropped with no ack; rr_ptr returns to 0.
- out_data is updated only on a grant edge.

Optional Feature:
Macro CACHE_ARB_LOCK_EN.
- When defined: adds input lock, N bits.
  - If lock[sel] is high on the accept cycle, the arbiter skips re-arbitration and stays granted to the same requester.
  - The IDLE cycle is still taken; ack pulses in that cycle.
  - The next arbitration grants sel again, provided req[sel] is high in the following IDLE cycle, so multi-beat bursts are not interleaved.
  - rr_ptr does not advance while lock is held.
  - When the locked requester drops req, normal round-robin resumes from (sel+1).
- When not defined: the port does not exist and behaviour is pure round-robin as above.

Test Plan:
- Reset, then req=8'b0000_0100 with payload slice 2 = 0xDEADBEEF, out_ready=1 → out_valid=1 one cycle after req; sel=2, out_data=0xDEADBEEF, ack=8'b0000_0100 for one cycle; rr_ptr=3.
- req=8'hFF held, all payloads distinct, out_ready=1 → grant sequence 0,1,2,…,7,0, one grant every 2 cycles, each ack one-hot and matching sel.
- Grant requester 5, hold out_ready=0 for 10 cycles while toggling in_bus and req → sel=5 and out_data unchanged, no ack; release out_ready → single ack[5].
- Assert reset while in GRANT with out_valid=1 → out_valid=0, ack=0 immediately, sel=0; after release with req=8'h01 → grant to 0.
- rr_ptr=7, req=8'b1000_0001 → 7 wins first, then 0; wrap-around verified.
- With CACHE_ARB_LOCK_EN defined: req=8'h09, lock[0]=1 for 3 beats → requester 0 granted 3 consecutive times, then 3 granted after lock drops.
